// File: rtl/arbiter_rr_4_to_1.sv
// Round-robin arbiter draining four first-word-fallthrough FIFOs into one downstream FIFO.
// The pop is combinational from the current state and pointer; the forwarded word, push, grant and count are registered.
module arbiter_rr_4_to_1 #(
    parameter int DATA_WIDTH = 16,
    parameter int N_INPUTS   = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [N_INPUTS-1:0]            empty,
    input  logic                           almost_full,
    output logic [N_INPUTS-1:0]            pop,
    output logic [DATA_WIDTH-1:0]          data_out,
    output logic                           push,
    output logic [1:0]                     grant_id,
    output logic [1:0]                     state,
    output logic [CNT_WIDTH-1:0]           count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSE  = 2'd2
    } arbState_t;

    arbState_t             stateReg;
    arbState_t             stateNext;
    logic [1:0]            lastGrant;
    logic [1:0]            probeLane;
    logic [1:0]            selLane_p0;
    logic                  laneFound;
    logic                  anyReq;
    logic                  grantVld_p0;
    logic [DATA_WIDTH-1:0] laneWord [N_INPUTS];

    always_comb begin
        for (int i = 0; i < N_INPUTS; i++) begin
            laneWord[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage p0: search starts just after the last served lane and wraps back to it.
    always_comb begin
        laneFound  = 1'b0;
        selLane_p0 = lastGrant;
        probeLane  = lastGrant;
        for (int k = 1; k <= 4; k++) begin
            probeLane = lastGrant + 2'(k);
            if (!laneFound && !empty[probeLane]) begin
                laneFound  = 1'b1;
                selLane_p0 = probeLane;
            end
        end
    end

    assign anyReq      = !(&empty);
    assign grantVld_p0 = (stateReg == ACTIVE) && enable && !almost_full && anyReq && laneFound;
    assign pop         = grantVld_p0 ? (N_INPUTS'(1) << selLane_p0) : '0;
    assign state       = stateReg;

    always_comb begin
        stateNext = stateReg;
        if (!enable) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE:    stateNext = ACTIVE;
                ACTIVE:  if (almost_full) stateNext = PAUSE;
                PAUSE:   if (!almost_full) stateNext = ACTIVE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // Stage p1: forwarded word and push strobe toward the downstream FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg  <= IDLE;
            lastGrant <= 2'd3;
            push      <= 1'b0;
            data_out  <= '0;
            grant_id  <= 2'd0;
            count     <= '0;
        end else begin
            stateReg <= stateNext;
            if (grantVld_p0) begin
                data_out  <= laneWord[selLane_p0];
                push      <= 1'b1;
                grant_id  <= selLane_p0;
                lastGrant <= selLane_p0;
                count     <= count + CNT_WIDTH'(1);
            end else begin
                push <= 1'b0;
            end
        end
    end

endmodule
